div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: sequential 32-step restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: fixed; done pulses 33 clocks after the accepting edge (34th cycle counting the start cycle).
// Backpressure: none; start is only sampled in IDLE, so requests made while busy are dropped.
// Ports: clk/rst (sync, active-high); start/op/DataA/DataB/AddrD_in request;
//        busy/done status; DataD/AddrD/RegWEn register bank write port.
module div_unit #(
   parameter int WIDTH_DATA_LENGTH = 32,
   parameter int WIDTH_ADDR_LENGTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   op,
   input  logic [WIDTH_DATA_LENGTH-1:0] DataA,
   input  logic [WIDTH_DATA_LENGTH-1:0] DataB,
   input  logic [WIDTH_ADDR_LENGTH-1:0] AddrD_in,
   output logic                         busy,
   output logic                         done,
   output logic [WIDTH_DATA_LENGTH-1:0] DataD,
   output logic [WIDTH_ADDR_LENGTH-1:0] AddrD,
   output logic                         RegWEn
);

   localparam int W  = WIDTH_DATA_LENGTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   sel_rem_q, sel_rem_d;   // op[1]: remainder wanted
   logic                   qneg_q, qneg_d;         // negate quotient at the end
   logic                   rneg_q, rneg_d;         // negate remainder at the end
   logic [W-1:0]           dvs_q, dvs_d;           // divisor magnitude
   logic [W-1:0]           quo_q, quo_d;           // dividend shifts out, quotient shifts in
   logic [W-1:0]           rem_q, rem_d;           // partial remainder
   logic [W-1:0]           data_q, data_d;
   logic [WIDTH_ADDR_LENGTH-1:0] addr_q, addr_d;

   logic                   a_neg, b_neg;
   logic [W:0]             shifted, trial;
   logic [W-1:0]           step_quo, step_rem, fin_quo, fin_rem;

   // One restoring step. The partial remainder is always below the divisor,
   // so the trial difference fits W bits when non-negative and bit W acts as
   // the borrow. A zero divisor never borrows, yielding an all-ones quotient
   // and a remainder equal to the dividend magnitude.
   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      trial   = shifted - {1'b0, dvs_q};
      if (!trial[W]) begin
         step_rem = trial[W-1:0];
         step_quo = {quo_q[W-2:0], 1'b1};
      end else begin
         step_rem = shifted[W-1:0];
         step_quo = {quo_q[W-2:0], 1'b0};
      end
      fin_quo = qneg_q ? (~step_quo + 1'b1) : step_quo;
      fin_rem = rneg_q ? (~step_rem + 1'b1) : step_rem;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_rem_d = sel_rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      data_d    = data_q;
      addr_d    = addr_q;
      a_neg     = ~op[0] & DataA[W-1];
      b_neg     = ~op[0] & DataB[W-1];

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CALC;
               cnt_d     = '0;
               sel_rem_d = op[1];
               // Divide-by-zero keeps the unsigned all-ones quotient for DIV too.
               qneg_d    = (a_neg ^ b_neg) & (DataB != '0);
               rneg_d    = a_neg;
               quo_d     = a_neg ? (~DataA + 1'b1) : DataA;
               dvs_d     = b_neg ? (~DataB + 1'b1) : DataB;
               rem_d     = '0;
               addr_d    = AddrD_in;
            end
         end
         CALC: begin
            quo_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
               data_d  = sel_rem_q ? fin_rem : fin_quo;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_rem_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         dvs_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_rem_q <= sel_rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign RegWEn = (state_q == DONE) && (addr_q != '0);
   assign DataD  = data_q;
   assign AddrD  = addr_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with hand-computed results for div_unit.
// Latency: checks done arrives 33 clocks after the accepting edge.
// Backpressure: exercises ignored start while busy, reset abort, back-to-back issue.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] DataA, DataB;
   logic [4:0]  AddrD_in;
   logic        busy, done, RegWEn;
   logic [31:0] DataD;
   logic [4:0]  AddrD;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH_DATA_LENGTH(32), .WIDTH_ADDR_LENGTH(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .DataA(DataA), .DataB(DataB),
      .AddrD_in(AddrD_in), .busy(busy), .done(done), .DataD(DataD), .AddrD(AddrD),
      .RegWEn(RegWEn)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after DONE.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] ad,
                         input logic [31:0] exp, input bit poke);
      int n = 0;
      bit got_done = 0;
      bit busy_gap = 0;
      start = 1'b1; op = o; DataA = a; DataB = b; AddrD_in = ad;
      @(posedge clk);
      #1;
      start = 1'b0; DataA = ~a; DataB = ~b; AddrD_in = ~ad;
      while (n < 100 && !got_done) begin
         @(negedge clk);
         n++;
         if (poke && n == 10) begin start = 1'b1; op = ~o; AddrD_in = ad + 5'd1; end
         if (poke && n == 11) start = 1'b0;
         if (done) got_done = 1;
         else if (!busy) busy_gap = 1;
      end
      chk({tag, " latency"}, 32'(n), 32'd33);
      chk({tag, " busy_gap"}, {31'b0, busy_gap}, 32'd0);
      chk({tag, " DataD"}, DataD, exp);
      chk({tag, " AddrD"}, {27'b0, AddrD}, {27'b0, ad});
      chk({tag, " RegWEn"}, {31'b0, RegWEn}, {31'b0, (ad != 5'd0)});
      chk({tag, " busy_done"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
      chk({tag, " wen_pulse"}, {31'b0, RegWEn}, 32'd0);
      chk({tag, " busy_idle"}, {31'b0, busy}, 32'd0);
      chk({tag, " DataD_hold"}, DataD, exp);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; start = 1'b0; op = 2'b00; DataA = '0; DataB = '0; AddrD_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst wen", {31'b0, RegWEn}, 32'd0);
      chk("rst DataD", DataD, 32'd0);
      chk("rst AddrD", {27'b0, AddrD}, 32'd0);

      run_op("divu_100_7",  2'b01, 32'd100,       32'd7,         5'd5,  32'd14,        0);
      run_op("remu_100_7",  2'b11, 32'd100,       32'd7,         5'd6,  32'd2,         0);
      run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 0);
      run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 0);
      run_op("div_7_m2",    2'b00, 32'd7,         32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 0);
      run_op("rem_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1,         0);
      run_op("divu_x_0",    2'b01, 32'h0000_0055, 32'd0,         5'd11, 32'hFFFF_FFFF, 0);
      run_op("remu_x_0",    2'b11, 32'h0000_1234, 32'd0,         5'd12, 32'h0000_1234, 0);
      run_op("div_neg_0",   2'b00, 32'hFFFF_FFFF, 32'd0,         5'd13, 32'hFFFF_FFFF, 0);
      run_op("rem_neg_0",   2'b10, 32'hFFFF_FFFB, 32'd0,         5'd14, 32'hFFFF_FFFB, 0);
      run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
      run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0);
      run_op("divu_big",    2'b01, 32'hFFFF_FFFF, 32'd1,         5'd17, 32'hFFFF_FFFF, 0);
      run_op("divu_poke",   2'b01, 32'd1000,      32'd9,         5'd18, 32'd111,       1);
      run_op("divu_addr0",  2'b01, 32'd50,        32'd5,         5'd0,  32'd10,        0);

      // Reset during CALC aborts the operation without a write.
      start = 1'b1; op = 2'b01; DataA = 32'd77; DataB = 32'd3; AddrD_in = 5'd20;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort AddrD", {27'b0, AddrD}, 32'd0);
      chk("abort DataD", DataD, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || RegWEn) seen = 1;
      end
      chk("abort no_done", {31'b0, seen}, 32'd0);

      run_op("after_abort", 2'b01, 32'd77,        32'd3,         5'd21, 32'd25,        0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
